// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: drains a fifo_v3-style pop interface into a registered
// valid/ready stream through a 2-entry skid buffer (head + skid).
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   clr_i                    sync clear: drop held entries, zero data regs
//   flush_i                  sync flush: drop held entries, keep data regs
//   fifo_empty_i/fifo_data_i FIFO empty flag and head data
//   fifo_pop_o               pop the FIFO head this cycle (no ready_i path)
//   valid_o/ready_i/data_o   outgoing stream
//   occupancy_o              entries held internally (0..2)
module fifo_pop_stream #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       flush_i,
   input  logic       fifo_empty_i,
   input  dtype       fifo_data_i,
   output logic       fifo_pop_o,
   output logic       valid_o,
   input  logic       ready_i,
   output dtype       data_o,
   output logic [1:0] occupancy_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e state_q, state_d;
   dtype   head_q, head_d;
   dtype   skid_q, skid_d;
   logic   hs;

   // State and data registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   // Next state, data movement and output decode
   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      skid_d      = skid_q;
      valid_o     = 1'b0;
      occupancy_o = 2'd0;

      unique case (state_q)
         ST_ONE:  begin valid_o = 1'b1; occupancy_o = 2'd1; end
         ST_TWO:  begin valid_o = 1'b1; occupancy_o = 2'd2; end
         default: begin valid_o = 1'b0; occupancy_o = 2'd0; end
      endcase

      // Pop only looks at held-entry count, never at the sink's ready
      fifo_pop_o = ~fifo_empty_i & (state_q != ST_TWO) & ~flush_i & ~clr_i;
      hs         = valid_o & ready_i;

      if (clr_i) begin
         state_d = ST_EMPTY;
         head_d  = '0;
         skid_d  = '0;
      end else if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (fifo_pop_o) begin
                  state_d = ST_ONE;
                  head_d  = fifo_data_i;
               end
            end
            ST_ONE: begin
               if (hs && fifo_pop_o) begin
                  head_d = fifo_data_i;
               end else if (hs) begin
                  state_d = ST_EMPTY;
               end else if (fifo_pop_o) begin
                  state_d = ST_TWO;
                  skid_d  = fifo_data_i;
               end
            end
            ST_TWO: begin
               if (hs) begin
                  state_d = ST_ONE;
                  head_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign data_o = head_q;

`ifndef SYNTHESIS
   a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      fifo_pop_o |-> !fifo_empty_i);
   a_stream_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i && !flush_i && !clr_i) |=> (valid_o && $stable(data_o)));
   a_legal_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
      state_q inside {ST_EMPTY, ST_ONE, ST_TWO});
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Bench for fifo_pop_stream: a model FIFO feeds the DUT, popped entries go
// into a scoreboard queue and are compared on each stream handshake.
module tb_fifo_pop_stream;

   logic        clk;
   logic        rst_n;
   logic        clr_i;
   logic        flush_i;
   logic        fifo_empty_i;
   logic [31:0] fifo_data_i;
   logic        fifo_pop_o;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] data_o;
   logic [1:0]  occupancy_o;

   logic [31:0] fq[$];   // model FIFO contents, head at index 0
   logic [31:0] sb[$];   // entries popped from the FIFO, not yet delivered
   int          n_checks;
   int          n_pass;

   fifo_pop_stream #(.DATA_WIDTH(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clr_i       (clr_i),
      .flush_i     (flush_i),
      .fifo_empty_i(fifo_empty_i),
      .fifo_data_i (fifo_data_i),
      .fifo_pop_o  (fifo_pop_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .occupancy_o (occupancy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_fifo();
      fifo_empty_i = (fq.size() == 0);
      fifo_data_i  = (fq.size() == 0) ? 32'h0 : fq[0];
   endtask

   // Advance one clock: a popped head moves from the FIFO to the scoreboard
   task automatic tick();
      logic        pop_s;
      logic [31:0] d_s;
      pop_s = fifo_pop_o;
      d_s   = fifo_data_i;
      @(posedge clk);
      if (pop_s && fq.size() != 0) begin
         void'(fq.pop_front());
         sb.push_back(d_s);
      end
      @(negedge clk);
      apply_fifo();
      #1;
   endtask

   task automatic drain();
      fq.delete();
      apply_fifo();
      ready_i = 1'b1;
      repeat (4) tick();
      sb.delete();
      ready_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
      fq.delete(); sb.delete();
      apply_fifo();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_o); else n_pass++;
      n_checks++; if (fifo_pop_o !== 1'b0) $display("FAIL reset_pop: got %b expected 0", fifo_pop_o); else n_pass++;
      n_checks++; if (data_o !== 32'h0) $display("FAIL reset_data: got %h expected 0", data_o); else n_pass++;
      n_checks++; if (occupancy_o !== 2'd0) $display("FAIL reset_occ: got %0d expected 0", occupancy_o); else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_stream_ready();
      logic [31:0] exp_d[3];
      exp_d = '{32'hA, 32'hB, 32'hC};
      fq.delete(); sb.delete();
      fq.push_back(32'hA); fq.push_back(32'hB); fq.push_back(32'hC);
      ready_i = 1'b1;
      apply_fifo(); #1;
      for (int c = 0; c < 6; c++) begin
         logic exp_pop, exp_valid;
         exp_pop   = (c < 3);
         exp_valid = (c >= 1 && c <= 3);
         n_checks++; if (fifo_pop_o !== exp_pop) $display("FAIL ready_pop c%0d: got %b expected %b", c, fifo_pop_o, exp_pop); else n_pass++;
         n_checks++; if (valid_o !== exp_valid) $display("FAIL ready_valid c%0d: got %b expected %b", c, valid_o, exp_valid); else n_pass++;
         if (exp_valid) begin
            n_checks++; if (data_o !== exp_d[c-1]) $display("FAIL ready_data c%0d: got %h expected %h", c, data_o, exp_d[c-1]); else n_pass++;
            if (sb.size() != 0) void'(sb.pop_front());
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic        exp_pop[8];
      logic [1:0]  exp_occ[8];
      logic [31:0] exp_dat[8];
      exp_pop = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_occ = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
      exp_dat = '{32'h0, 32'hA, 32'hA, 32'hA, 32'hA, 32'hB, 32'hC, 32'h0};
      fq.delete(); sb.delete();
      fq.push_back(32'hA); fq.push_back(32'hB); fq.push_back(32'hC);
      apply_fifo();
      for (int c = 0; c < 8; c++) begin
         ready_i = (c >= 4);
         #1;
         n_checks++; if (fifo_pop_o !== exp_pop[c]) $display("FAIL bp_pop c%0d: got %b expected %b", c, fifo_pop_o, exp_pop[c]); else n_pass++;
         n_checks++; if (occupancy_o !== exp_occ[c]) $display("FAIL bp_occ c%0d: got %0d expected %0d", c, occupancy_o, exp_occ[c]); else n_pass++;
         n_checks++; if (valid_o !== (exp_occ[c] != 2'd0)) $display("FAIL bp_valid c%0d: got %b expected %b", c, valid_o, exp_occ[c] != 2'd0); else n_pass++;
         if (exp_occ[c] != 2'd0) begin
            n_checks++; if (data_o !== exp_dat[c]) $display("FAIL bp_data c%0d: got %h expected %h", c, data_o, exp_dat[c]); else n_pass++;
         end
         if (valid_o && ready_i && sb.size() != 0) begin
            logic [31:0] e;
            e = sb.pop_front();
            n_checks++; if (data_o !== e) $display("FAIL bp_order c%0d: got %h expected %h", c, data_o, e); else n_pass++;
         end
         tick();
      end
      ready_i = 1'b0;
   endtask

   task automatic test_flush_clear();
      for (int k = 0; k < 2; k++) begin
         logic [31:0] exp_head;
         exp_head = (k == 0) ? 32'hA : 32'h0;
         fq.delete(); sb.delete();
         fq.push_back(32'hA); fq.push_back(32'hB); fq.push_back(32'hC);
         ready_i = 1'b0;
         apply_fifo(); #1;
         tick(); tick();
         n_checks++; if (occupancy_o !== 2'd2) $display("FAIL fc%0d_pre_occ: got %0d expected 2", k, occupancy_o); else n_pass++;
         if (k == 0) flush_i = 1'b1; else clr_i = 1'b1;
         #1;
         n_checks++; if (fifo_pop_o !== 1'b0) $display("FAIL fc%0d_pop: got %b expected 0", k, fifo_pop_o); else n_pass++;
         tick();
         flush_i = 1'b0; clr_i = 1'b0;
         #1;
         sb.delete();
         n_checks++; if (valid_o !== 1'b0) $display("FAIL fc%0d_valid: got %b expected 0", k, valid_o); else n_pass++;
         n_checks++; if (occupancy_o !== 2'd0) $display("FAIL fc%0d_occ: got %0d expected 0", k, occupancy_o); else n_pass++;
         n_checks++; if (data_o !== exp_head) $display("FAIL fc%0d_data: got %h expected %h", k, data_o, exp_head); else n_pass++;
         drain();
      end
   endtask

   task automatic test_random();
      int gaps;
      int bad;
      gaps = 0;
      bad  = 0;
      fq.delete(); sb.delete();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         int mode, push_pct, rdy_pct;
         logic        exp_pop;
         logic [1:0]  exp_occ;
         mode = (cyc / 1000) % 3;
         push_pct = (mode == 0) ? 100 : (mode == 1) ? 50 : 20;
         rdy_pct  = (mode == 0) ? 100 : (mode == 1) ? 50 : 25;
         if (fq.size() < 8 && $urandom_range(99) < push_pct) fq.push_back($urandom);
         ready_i = ($urandom_range(99) < rdy_pct);
         apply_fifo();
         #1;
         exp_pop = (fq.size() != 0) && (sb.size() < 2);
         exp_occ = 2'(sb.size());
         n_checks++; if (fifo_pop_o !== exp_pop) begin bad++; $display("FAIL rnd_pop cyc%0d: got %b expected %b", cyc, fifo_pop_o, exp_pop); end else n_pass++;
         n_checks++; if (fifo_pop_o === 1'b1 && fifo_empty_i === 1'b1) begin bad++; $display("FAIL rnd_pop_empty cyc%0d: got pop=1 expected 0", cyc); end else n_pass++;
         n_checks++; if (occupancy_o !== exp_occ) begin bad++; $display("FAIL rnd_occ cyc%0d: got %0d expected %0d", cyc, occupancy_o, exp_occ); end else n_pass++;
         n_checks++; if (valid_o !== (sb.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc%0d: got %b expected %b", cyc, valid_o, sb.size() != 0); end else n_pass++;
         if (sb.size() != 0) begin
            n_checks++; if (data_o !== sb[0]) begin bad++; $display("FAIL rnd_data cyc%0d: got %h expected %h", cyc, data_o, sb[0]); end else n_pass++;
         end
         if (mode == 0 && (cyc % 1000) >= 4 && !(valid_o && fifo_pop_o)) gaps++;
         if (valid_o && ready_i && sb.size() != 0) void'(sb.pop_front());
         if (bad > 20) begin
            $display("FAIL rnd_abort: got %0d errors expected 0", bad);
            break;
         end
         tick();
      end
      n_checks++; if (gaps !== 0) $display("FAIL rnd_throughput: got %0d gaps expected 0", gaps); else n_pass++;
      drain();
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_stream_ready();
      test_backpressure();
      test_flush_clear();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
